// File: rtl/data_memory_arbiter_pkg.sv
// =============================================================================
// Module   : data_memory_arbiter_pkg
// Purpose  : Shared types, constants and helpers for the data memory arbiter.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package data_memory_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arbiter_state_t;

    localparam int MAX_REQUESTERS = 8;

    function automatic int next_index(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_arbiter_round_robin_picker.sv
// =============================================================================
// Module   : round_robin_picker
// Purpose  : Combinational search for the first active request at or after
//            the fairness pointer, wrapping modulo NUM_REQUESTERS.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module round_robin_picker
    import data_memory_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2
) (
    input  logic [NUM_REQUESTERS-1:0]         req,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] pointer,
    output logic                              found,
    output logic [$clog2(NUM_REQUESTERS)-1:0] winner
);

    localparam int c_idx_w = $clog2(NUM_REQUESTERS);

    int w_idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        w_idx  = 0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            w_idx = (int'(pointer) + k) % NUM_REQUESTERS;
            if (!found && req[w_idx]) begin
                found  = 1'b1;
                winner = c_idx_w'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_arbiter.sv
// =============================================================================
// Module   : data_memory_arbiter
// Purpose  : Round-robin arbiter sharing a single-port data memory between
//            masters, with bounded lock and registered read return.
//            Optional per-requester grant counters: DATA_MEMORY_ARBITER_COUNTERS_EN
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int LOCK_LIMIT     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQUESTERS-1:0]            req,
    input  logic [NUM_REQUESTERS-1:0]            req_lock,
    input  logic [NUM_REQUESTERS-1:0]            req_write,
    input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_wdata,
`ifdef DATA_MEMORY_ARBITER_COUNTERS_EN
    input  logic                                 count_clear,
    output logic [NUM_REQUESTERS*16-1:0]         grant_count,
`endif
    output logic [NUM_REQUESTERS-1:0]            gnt,
    output logic [NUM_REQUESTERS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0]             address_rw,
    output logic [DATA_WIDTH-1:0]                data_in,
    input  logic [DATA_WIDTH-1:0]                data_out
);

    localparam int         c_idx_w      = $clog2(NUM_REQUESTERS);
    localparam logic [3:0] c_lock_limit = 4'(LOCK_LIMIT);

    arbiter_state_t            r_state;
    arbiter_state_t            w_state_next;
    logic [c_idx_w-1:0]        r_owner;
    logic [c_idx_w-1:0]        r_rr_pointer;
    logic [c_idx_w-1:0]        w_winner;
    logic                      w_found;
    logic [3:0]                r_lock_count;
    logic                      w_owner_req;
    logic                      w_owner_write;
    logic                      w_owner_lock;
    logic                      w_commit;
    logic                      w_stay;
    logic [NUM_REQUESTERS-1:0] r_rvalid;
    logic [DATA_WIDTH-1:0]     r_rdata;

    round_robin_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_picker (
        .req     (req),
        .pointer (r_rr_pointer),
        .found   (w_found),
        .winner  (w_winner)
    );

    assign w_owner_req   = req[r_owner];
    assign w_owner_write = req_write[r_owner];
    assign w_owner_lock  = req_lock[r_owner];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory-side outputs are decoded from state so an async reset kills a
    // write that is in flight.
    always_comb begin
        w_state_next        = r_state;
        w_stay              = 1'b0;
        w_commit            = 1'b0;
        gnt                 = '0;
        memory_write_enable = 1'b0;
        address_rw          = '0;
        data_in             = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                gnt[r_owner]        = 1'b1;
                address_rw          = req_address[r_owner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                data_in             = req_wdata[r_owner*DATA_WIDTH +: DATA_WIDTH];
                w_commit            = w_owner_req;
                memory_write_enable = w_owner_req & w_owner_write;
                w_stay              = w_owner_req & w_owner_lock & (r_lock_count < c_lock_limit);
                w_state_next        = w_stay ? ACCESS : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= '0;
            r_rr_pointer <= '0;
            r_lock_count <= '0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_owner      <= w_winner;
                r_lock_count <= 4'd1;
            end
        end else if (w_stay) begin
            r_lock_count <= r_lock_count + 4'd1;
        end else begin
            r_rr_pointer <= c_idx_w'(next_index(int'(r_owner), NUM_REQUESTERS));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_commit && !w_owner_write) begin
                r_rvalid[r_owner] <= 1'b1;
                r_rdata           <= data_out;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

`ifdef DATA_MEMORY_ARBITER_COUNTERS_EN
    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_counters
        logic [15:0] r_count;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_count <= '0;
            end else if (count_clear) begin
                r_count <= '0;
            end else if (w_commit && (r_owner == c_idx_w'(g)) && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end

        assign grant_count[g*16 +: 16] = r_count;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
// =============================================================================
// Module   : tb_data_memory_arbiter
// Purpose  : Directed self-checking bench for data_memory_arbiter with a
//            behavioural single-port memory. Counter checks need
//            DATA_MEMORY_ARBITER_COUNTERS_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_lock, req_write;
    logic [31:0] req_address, req_wdata;
    logic [1:0]  gnt, rvalid;
    logic [15:0] rdata, address_rw, data_in, data_out;
    logic        memory_write_enable;
    logic        mem_load;
`ifdef DATA_MEMORY_ARBITER_COUNTERS_EN
    logic        count_clear = 1'b0;
    logic [31:0] grant_count;
`endif

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    data_memory_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .req_lock            (req_lock),
        .req_write           (req_write),
        .req_address         (req_address),
        .req_wdata           (req_wdata),
`ifdef DATA_MEMORY_ARBITER_COUNTERS_EN
        .count_clear         (count_clear),
        .grant_count         (grant_count),
`endif
        .gnt                 (gnt),
        .rvalid              (rvalid),
        .rdata               (rdata),
        .memory_write_enable (memory_write_enable),
        .address_rw          (address_rw),
        .data_in             (data_in),
        .data_out            (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            mem[16'h0010] <= 16'hBEEF;
        end else if (memory_write_enable) begin
            mem[address_rw] <= data_in;
        end
    end

    assign data_out = mem[address_rw];

    typedef struct {
        logic [1:0]  rq, lk, wr;
        logic [15:0] a0, a1, d0, d1;
        logic [1:0]  e_gnt, e_rv;
        logic        e_we;
        logic [15:0] e_addr, e_din, e_rdata;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(input logic [1:0] rq, lk, wr,
                                input logic [15:0] a0, a1, d0, d1,
                                input logic [1:0] e_gnt, e_rv, input logic e_we,
                                input logic [15:0] e_addr, e_din, e_rdata);
        vec_t v;
        v.rq = rq; v.lk = lk; v.wr = wr;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_we = e_we;
        v.e_addr = e_addr; v.e_din = e_din; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock, then drive the inputs for that cycle; outputs are
    // stable for comparison 2 time units later.
    task automatic step(input logic [1:0] rq, lk, wr, input logic [15:0] a0, a1, d0, d1);
        @(posedge clk);
        #2;
        req = rq; req_lock = lk; req_write = wr;
        req_address = {a1, a0};
        req_wdata   = {d1, d0};
        #2;
    endtask

    initial begin
        rst = 1'b0; mem_load = 1'b1;
        req = '0; req_lock = '0; req_write = '0; req_address = '0; req_wdata = '0;

        //          rq     lk     wr     a0      a1      d0       d1        gnt    rv     we    addr    din      rdata
        vecs[0]  = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h0);
        vecs[1]  = mk(2'b11, 2'b00, 2'b11, 16'h1,  16'h2,  16'h1111, 16'h2222, 2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h0);
        vecs[2]  = mk(2'b11, 2'b00, 2'b11, 16'h1,  16'h2,  16'h1111, 16'h2222, 2'b01, 2'b00, 1'b1, 16'h1,  16'h1111, 16'h0);
        vecs[3]  = mk(2'b10, 2'b00, 2'b11, 16'h1,  16'h2,  16'h1111, 16'h2222, 2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h0);
        vecs[4]  = mk(2'b10, 2'b00, 2'b11, 16'h1,  16'h2,  16'h1111, 16'h2222, 2'b10, 2'b00, 1'b1, 16'h2,  16'h2222, 16'h0);
        vecs[5]  = mk(2'b01, 2'b00, 2'b00, 16'h10, 16'h0,  16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h0);
        vecs[6]  = mk(2'b01, 2'b00, 2'b00, 16'h10, 16'h0,  16'h0,    16'h0,    2'b01, 2'b00, 1'b0, 16'h10, 16'h0,    16'h0);
        vecs[7]  = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b01, 1'b0, 16'h0,  16'h0,    16'hBEEF);
        vecs[8]  = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'hBEEF);
        vecs[9]  = mk(2'b10, 2'b00, 2'b00, 16'h0,  16'h1,  16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'hBEEF);
        vecs[10] = mk(2'b10, 2'b00, 2'b00, 16'h0,  16'h1,  16'h0,    16'h0,    2'b10, 2'b00, 1'b0, 16'h1,  16'h0,    16'hBEEF);
        vecs[11] = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b10, 1'b0, 16'h0,  16'h0,    16'h1111);
        vecs[12] = mk(2'b01, 2'b00, 2'b00, 16'h2,  16'h0,  16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h1111);
        vecs[13] = mk(2'b01, 2'b00, 2'b00, 16'h2,  16'h0,  16'h0,    16'h0,    2'b01, 2'b00, 1'b0, 16'h2,  16'h0,    16'h1111);
        vecs[14] = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b01, 1'b0, 16'h0,  16'h0,    16'h2222);
        // r1 locked against a pending r0: four back-to-back grants, then r0.
        vecs[15] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b00, 2'b00, 1'b0, 16'h0,  16'h0,    16'h2222);
        vecs[16] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b10, 2'b00, 1'b0, 16'h10, 16'h0,    16'h2222);
        vecs[17] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b10, 2'b10, 1'b0, 16'h10, 16'h0,    16'hBEEF);
        vecs[18] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b10, 2'b10, 1'b0, 16'h10, 16'h0,    16'hBEEF);
        vecs[19] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b10, 2'b10, 1'b0, 16'h10, 16'h0,    16'hBEEF);
        vecs[20] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b00, 2'b10, 1'b0, 16'h0,  16'h0,    16'hBEEF);
        vecs[21] = mk(2'b11, 2'b10, 2'b00, 16'h1,  16'h10, 16'h0,    16'h0,    2'b01, 2'b00, 1'b0, 16'h1,  16'h0,    16'hBEEF);
        vecs[22] = mk(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  16'h0,    16'h0,    2'b00, 2'b01, 1'b0, 16'h0,  16'h0,    16'h1111);

        #2;
        check("reset gnt",   {30'd0, gnt}, 32'd0);
        check("reset rdata", {16'd0, rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1; mem_load = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rq, vecs[i].lk, vecs[i].wr, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            check($sformatf("v%0d gnt", i),    {30'd0, gnt},    {30'd0, vecs[i].e_gnt});
            check($sformatf("v%0d rvalid", i), {30'd0, rvalid}, {30'd0, vecs[i].e_rv});
            check($sformatf("v%0d we", i),     {31'd0, memory_write_enable}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d addr", i),   {16'd0, address_rw}, {16'd0, vecs[i].e_addr});
            check($sformatf("v%0d din", i),    {16'd0, data_in},    {16'd0, vecs[i].e_din});
            check($sformatf("v%0d rdata", i),  {16'd0, rdata},      {16'd0, vecs[i].e_rdata});
        end
        check("mem[1]", {16'd0, mem[16'h1]}, 32'h1111);
        check("mem[2]", {16'd0, mem[16'h2]}, 32'h2222);

        // Protocol violation: r0 write granted, req dropped in the access cycle.
        step(2'b01, 2'b00, 2'b01, 16'h3, 16'h0, 16'h3333, 16'h0);
        check("viol idle gnt", {30'd0, gnt}, 32'd0);
        step(2'b00, 2'b00, 2'b01, 16'h3, 16'h0, 16'h3333, 16'h0);
        check("viol gnt", {30'd0, gnt}, 32'd1);
        check("viol we",  {31'd0, memory_write_enable}, 32'd0);
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check("viol after gnt",    {30'd0, gnt}, 32'd0);
        check("viol after rvalid", {30'd0, rvalid}, 32'd0);
        check("viol mem[3]", {16'd0, mem[16'h3]}, 32'd0);
        step(2'b11, 2'b00, 2'b00, 16'h1, 16'h2, 16'h0, 16'h0);
        step(2'b11, 2'b00, 2'b00, 16'h1, 16'h2, 16'h0, 16'h0);
        check("viol pointer advanced", {30'd0, gnt}, 32'd2);
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check("viol rdata", {16'd0, rdata}, 32'h2222);

        // Async reset during an r1 write access.
        step(2'b10, 2'b00, 2'b10, 16'h0, 16'h4, 16'h0, 16'h4444);
        step(2'b10, 2'b00, 2'b10, 16'h0, 16'h4, 16'h0, 16'h4444);
        check("rst pre gnt", {30'd0, gnt}, 32'd2);
        check("rst pre we",  {31'd0, memory_write_enable}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst async gnt",  {30'd0, gnt}, 32'd0);
        check("rst async we",   {31'd0, memory_write_enable}, 32'd0);
        check("rst async addr", {16'd0, address_rw}, 32'd0);
        check("rst async din",  {16'd0, data_in}, 32'd0);
        check("rst async rdata", {16'd0, rdata}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 2'b11; req_write = 2'b00; req_lock = 2'b00;
        req_address = {16'h6, 16'h5}; req_wdata = '0;
        check("rst mem[4]", {16'd0, mem[16'h4]}, 32'd0);
        step(2'b11, 2'b00, 2'b00, 16'h5, 16'h6, 16'h0, 16'h0);
        check("rst first grant", {30'd0, gnt}, 32'd1);
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

`ifdef DATA_MEMORY_ARBITER_COUNTERS_EN
        count_clear = 1'b1;
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        count_clear = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step(2'b01, 2'b00, 2'b00, 16'h10, 16'h0, 16'h0, 16'h0);
            step(2'b01, 2'b00, 2'b00, 16'h10, 16'h0, 16'h0, 16'h0);
        end
        for (int n = 0; n < 5; n++) begin
            step(2'b10, 2'b00, 2'b00, 16'h0, 16'h10, 16'h0, 16'h0);
            step(2'b10, 2'b00, 2'b00, 16'h0, 16'h10, 16'h0, 16'h0);
        end
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check("count r0", {16'd0, grant_count[15:0]},  32'd3);
        check("count r1", {16'd0, grant_count[31:16]}, 32'd5);
        count_clear = 1'b1;
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        count_clear = 1'b0;
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check("count clr", grant_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
